// File: rtl/instruction_loader_if.sv
// instruction_loader_if: byte-stream input and instruction-memory write/status outputs of the loader
interface instruction_loader_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  iByteValid;
    logic [7:0]            iByte;
    logic                  oByteReady;
    logic                  oWriteEnable;
    logic [ADDR_WIDTH-1:0] oWriteAddress;
    logic [27:0]           oWriteData;
    logic                  oCpuReset;
    logic                  oBusy;
    logic                  oDone;
    logic                  oError;
    modport master (
        output iByteValid, iByte,
        input  oByteReady, oWriteEnable, oWriteAddress, oWriteData, oCpuReset, oBusy, oDone, oError
    );
    modport slave (
        input  iByteValid, iByte,
        output oByteReady, oWriteEnable, oWriteAddress, oWriteData, oCpuReset, oBusy, oDone, oError
    );
endinterface

// File: rtl/instruction_loader.sv
// instruction_loader: parses a framed byte stream into 28-bit instructions, writes them to
// instruction memory, verifies an 8-bit checksum and holds the core in reset until a clean load.
module instruction_loader #(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic                 Clock,
    input  logic                 Reset,
    instruction_loader_if.slave  bus
);
    typedef enum logic [3:0] {
        IDLE, LEN_HI, LEN_LO, BYTE0, BYTE1, BYTE2, BYTE3, WRITE, CHECK, DONE, ERROR
    } state_e;
    localparam logic [16:0] DEPTH = 17'(1) << ADDR_WIDTH;
    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, waddr_q, waddr_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [7:0]            chk_q, chk_d;
    logic [19:0]           asm_q, asm_d;
    logic [27:0]           wdata_q, wdata_d;
    logic                  ready, accept, restart;
    logic [15:0]           len;
    logic [7:0]            b;
    assign b       = bus.iByte;
    assign ready   = state_q != WRITE;
    assign accept  = bus.iByteValid && ready;
    assign restart = accept && b == SYNC_BYTE;
    assign len     = {cnt_q[15:8], b};
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        chk_d   = chk_q;
        asm_d   = asm_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE, DONE, ERROR: if (restart) begin
                state_d = LEN_HI;
                addr_d  = '0;
                chk_d   = '0;
            end
            LEN_HI: if (accept) begin
                cnt_d   = {b, 8'h00};
                state_d = LEN_LO;
            end
            LEN_LO: if (accept) begin
                cnt_d   = len;
                state_d = {1'b0, len} > DEPTH ? ERROR : len == 16'd0 ? CHECK : BYTE0;
            end
            BYTE0, BYTE1, BYTE2: if (accept) begin
                asm_d   = {asm_q[11:0], b};
                chk_d   = chk_q + b;
                state_d = state_q == BYTE0 ? BYTE1 : state_q == BYTE1 ? BYTE2 : BYTE3;
            end
            BYTE3: if (accept) begin
                // only byte0's low nibble survives the 20-bit shift, becoming data[27:24]
                asm_d   = {asm_q[11:0], b};
                chk_d   = chk_q + b;
                waddr_d = addr_q;
                wdata_d = {asm_q[19:0], b};
                state_d = WRITE;
            end
            WRITE: begin
                addr_d  = addr_q + ADDR_WIDTH'(1);
                cnt_d   = cnt_q - 16'd1;
                state_d = cnt_q == 16'd1 ? CHECK : BYTE0;
            end
            CHECK: if (accept) state_d = b == chk_q ? DONE : ERROR;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            chk_q   <= '0;
            asm_q   <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            chk_q   <= chk_d;
            asm_q   <= asm_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end
    assign bus.oByteReady    = ready;
    assign bus.oWriteEnable  = state_q == WRITE;
    assign bus.oWriteAddress = waddr_q;
    assign bus.oWriteData    = wdata_q;
    assign bus.oCpuReset     = state_q != DONE;
    assign bus.oBusy         = !(state_q == IDLE || state_q == DONE || state_q == ERROR);
    assign bus.oDone         = state_q == DONE;
    assign bus.oError        = state_q == ERROR;
endmodule
